mem_port_arbiter: RTL

Shares the single-port program/data RAM between the instruction-fetch requester and the data-memory (load/store) requester. Issues at most one RAM access per clk, tracks in-flight reads through a fixed-latency tag pipe, and returns read data to the owning requester. Fetch-side back-pressure goes to the pipeline controller as stall_if. Sits between program_counter/fetch, the memory-access stage and p_ram.

---
 rtl/xm23_mem_pkg.sv | 26 ++
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter_rd_tag_pipe.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 4 files changed

// File: rtl/xm23_mem_pkg.sv
// Shared types for the program/data RAM port arbiter.
// Owner tags, arbiter states and the tag-scrub helper.
package xm23_mem_pkg;

   localparam int RD_LATENCY_MAX = 3;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_IF,
      OWN_DM
   } owner_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_IF,
      S_DM
   } arb_state_t;

   function automatic owner_t scrub_if(
      input owner_t t,
      input logic   fl
   );
      return (fl && t == OWN_IF) ? OWN_NONE : t;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, RAM and pipeline-control signals of the RAM port arbiter.
// slave = arbiter side, master = environment side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 16
);
   logic              flush;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic              if_valid;
   logic [DATA_W-1:0] if_rdata;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_ack;
   logic              dm_valid;
   logic [DATA_W-1:0] dm_rdata;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_data;
   logic              ram_wren;
   logic [DATA_W-1:0] ram_q;
   logic              stall_if;
   logic              busy;

   modport slave (
      input  flush, if_req, if_addr,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      input  ram_q,
      output if_ack, if_valid, if_rdata,
      output dm_ack, dm_valid, dm_rdata,
      output ram_addr, ram_data, ram_wren,
      output stall_if, busy
   );

   modport master (
      output flush, if_req, if_addr,
      output dm_req, dm_we, dm_addr, dm_wdata,
      output ram_q,
      input  if_ack, if_valid, if_rdata,
      input  dm_ack, dm_valid, dm_rdata,
      input  ram_addr, ram_data, ram_wren,
      input  stall_if, busy
   );
endinterface

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// Fixed-latency owner-tag pipe tracking in-flight RAM reads.
// Flush rewrites every fetch tag, including the one being pushed.
module rd_tag_pipe
   import xm23_mem_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   flush_i,
   input  owner_t push_i,
   output owner_t exit_o,
   output logic   busy_o
);

   owner_t stg_q [DEPTH];
   owner_t stg_d [DEPTH];

   always_comb begin
      stg_d[0] = scrub_if(push_i, flush_i);
      for (int i = 1; i < DEPTH; i++) begin
         stg_d[i] = scrub_if(stg_q[i-1], flush_i);
      end
   end

   always_comb begin
      busy_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         busy_o = busy_o | (stg_q[i] != OWN_NONE);
      end
   end

   assign exit_o = stg_q[DEPTH-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            stg_q[i] <= OWN_NONE;
         end
      end else begin
         stg_q <= stg_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between fetch and load/store requesters.
// Define ARB_ROUND_ROBIN_EN for alternating grants instead of data priority.
module mem_port_arbiter
   import xm23_mem_pkg::*;
#(
   parameter int ADDR_W        = 15,
   parameter int DATA_W        = 16,
   parameter int RD_LATENCY    = 1,
   parameter int MAX_DM_STREAK = 4
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);

   arb_state_t        state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_q;

   logic   gnt_if;
   logic   gnt_dm;
   logic   pick_if;
   logic   wr;
   owner_t push;
   owner_t exit_tag;

`ifdef ARB_ROUND_ROBIN_EN
   assign pick_if = (state_q == S_DM);
`else
   localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

   logic [3:0] streak_q;
   logic [3:0] streak_d;

   assign pick_if = (streak_q == STREAK_MAX);

   always_comb begin
      streak_d = streak_q;
      unique case (1'b1)
         !bus.if_req || gnt_if:
            streak_d = '0;
         bus.if_req && gnt_dm && streak_q != STREAK_MAX:
            streak_d = streak_q + 4'd1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         streak_q <= '0;
      end else begin
         streak_q <= streak_d;
      end
   end

   // a live streak can only follow a data grant
   a_streak_dm: assert property (
      @(posedge clk) disable iff (!reset)
      (streak_q != '0) |-> (state_q == S_DM)
   );
`endif

   always_comb begin
      gnt_if = 1'b0;
      gnt_dm = 1'b0;
      unique case (1'b1)
         !reset: ;
         reset && bus.if_req && bus.dm_req: begin
            gnt_if = pick_if;
            gnt_dm = !pick_if;
         end
         reset && bus.if_req && !bus.dm_req:
            gnt_if = 1'b1;
         reset && !bus.if_req && bus.dm_req:
            gnt_dm = 1'b1;
         default: ;
      endcase
   end

   assign wr = gnt_dm & bus.dm_we;

   always_comb begin
      push = OWN_NONE;
      unique case (1'b1)
         gnt_if:       push = OWN_IF;
         gnt_dm && !wr: push = OWN_DM;
         default: ;
      endcase
   end

   rd_tag_pipe #(
      .DEPTH (RD_LATENCY)
   ) u_tags (
      .clk     (clk),
      .reset   (reset),
      .flush_i (bus.flush),
      .push_i  (push),
      .exit_o  (exit_tag),
      .busy_o  (bus.busy)
   );

   assign bus.if_ack   = gnt_if;
   assign bus.dm_ack   = gnt_dm;
   assign bus.stall_if = bus.if_req & ~gnt_if;
   assign bus.ram_wren = wr;
   assign bus.ram_data = wr ? bus.dm_wdata : wdata_q;
   assign bus.ram_addr = gnt_if ? bus.if_addr :
                         gnt_dm ? bus.dm_addr : addr_q;

   assign bus.if_valid = (exit_tag == OWN_IF);
   assign bus.dm_valid = (exit_tag == OWN_DM);
   assign bus.if_rdata = bus.if_valid ? bus.ram_q : if_rdata_q;
   assign bus.dm_rdata = bus.dm_valid ? bus.ram_q : dm_rdata_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= gnt_if ? S_IF :
                       gnt_dm ? S_DM : S_IDLE;
         addr_q     <= bus.ram_addr;
         wdata_q    <= bus.ram_data;
         if_rdata_q <= bus.if_rdata;
         dm_rdata_q <= bus.dm_rdata;
      end
   end

endmodule
